// File: rtl/chacha_poly_lane_packer_if.sv
// Word-in / lane-out bundle between the upstream word source, the lane packer
// and the ChaCha20-Poly1305 tag adapter.
//   master : upstream source plus adapter side (drives start, in_*, *_ready)
//   slave  : the lane packer (drives in_ready, lanes, length block, strobes)
interface chacha_poly_lane_packer_if;
    logic         start;
    logic         in_valid;
    logic [31:0]  in_data;
    logic [3:0]   in_keep;
    logic         in_last;
    logic         in_ready;
    logic         aad_valid;
    logic [127:0] aad_data;
    logic [15:0]  aad_keep;
    logic         aad_ready;
    logic         pld_valid;
    logic [127:0] pld_data;
    logic [15:0]  pld_keep;
    logic         pld_ready;
    logic         len_valid;
    logic [127:0] len_block;
    logic         len_ready;
    logic         aad_done;
    logic         pld_done;
    logic         lens_done;
    logic         busy;
    logic         err;

    modport master (
        output start, in_valid, in_data, in_keep, in_last,
        output aad_ready, pld_ready, len_ready,
        input  in_ready, aad_valid, aad_data, aad_keep,
        input  pld_valid, pld_data, pld_keep, len_valid, len_block,
        input  aad_done, pld_done, lens_done, busy, err
    );

    modport slave (
        input  start, in_valid, in_data, in_keep, in_last,
        input  aad_ready, pld_ready, len_ready,
        output in_ready, aad_valid, aad_data, aad_keep,
        output pld_valid, pld_data, pld_keep, len_valid, len_block,
        output aad_done, pld_done, lens_done, busy, err
    );
endinterface

// File: rtl/chacha_poly_lane_packer.sv
// Packs a 32-bit AAD+ciphertext word stream into 128-bit little-endian lanes
// for the ChaCha20-Poly1305 tag adapter, counts bytes per segment, emits the
// {ct_bytes, aad_bytes} length block and the aad/pld/lens phase strobes.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : chacha_poly_lane_packer_if.slave (word input, AAD lane,
//                payload lane, length block, done strobes, busy, err)
// Parameter LEN_W : byte counter width (1..64), zero-extended in len_block.
// Optional: define POLY_PACK_ERRCHK_EN to enable the sticky protocol checker
// behind err; otherwise err is tied low.
module chacha_poly_lane_packer #(
    parameter int unsigned LEN_W = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    chacha_poly_lane_packer_if.slave      bus
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANE_W = 128;
    localparam int unsigned KEEP_W = 16;
    localparam int unsigned WKEEP_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AAD,
        S_PLD,
        S_LEN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   pk_data_q, pk_data_d;
    logic [KEEP_W-1:0]   pk_keep_q, pk_keep_d;
    logic [1:0]          pk_idx_q, pk_idx_d;
    logic [LANE_W-1:0]   out_data_q, out_data_d;
    logic [KEEP_W-1:0]   out_keep_q, out_keep_d;
    logic                aad_vld_q, aad_vld_d;
    logic                pld_vld_q, pld_vld_d;
    logic                len_vld_q, len_vld_d;
    logic                seg_end_q, seg_end_d;
    logic [LEN_W-1:0]    aad_cnt_q, aad_cnt_d;
    logic [LEN_W-1:0]    pld_cnt_q, pld_cnt_d;
    logic                aad_done_q, aad_done_d;
    logic                pld_done_q, pld_done_d;
    logic                lens_done_q, lens_done_d;

    logic                in_ready_c;
    logic                accept_c;
    logic                hs_c;
    logic                out_empty_c;
    logic                close_c;
    logic                emit_c;
    logic [WORD_W-1:0]   word_c;
    logic [2:0]          pop_c;
    logic [LANE_W-1:0]   merged_data_c;
    logic [KEEP_W-1:0]   merged_keep_c;

    // Handshake qualifiers; a pending segment end blocks new words
    assign out_empty_c = !aad_vld_q && !pld_vld_q;
    assign in_ready_c  = ((state_q == S_AAD) || (state_q == S_PLD)) && out_empty_c && !seg_end_q;
    assign accept_c    = bus.in_valid && in_ready_c;
    assign hs_c        = (aad_vld_q && bus.aad_ready) || (pld_vld_q && bus.pld_ready);
    assign close_c     = (pk_idx_q == 2'd3) || bus.in_last;
    // An empty last word on a fresh lane carries no bytes: nothing to emit
    assign emit_c      = !(bus.in_last && (bus.in_keep == 4'h0) && (pk_idx_q == 2'd0));

    // Byte masking, popcount and merge of the incoming word into the lane
    always_comb begin
        word_c = '0;
        pop_c  = '0;
        for (int b = 0; b < 4; b++) begin
            if (bus.in_keep[b]) begin
                word_c[8*b +: 8] = bus.in_data[8*b +: 8];
                pop_c = pop_c + 3'd1;
            end
        end
        merged_data_c = pk_data_q;
        merged_keep_c = pk_keep_q;
        merged_data_c[WORD_W*pk_idx_q +: WORD_W]   = word_c;
        merged_keep_c[WKEEP_W*pk_idx_q +: WKEEP_W] = bus.in_keep;
    end

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        pk_data_d   = pk_data_q;
        pk_keep_d   = pk_keep_q;
        pk_idx_d    = pk_idx_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        aad_vld_d   = aad_vld_q;
        pld_vld_d   = pld_vld_q;
        len_vld_d   = len_vld_q;
        seg_end_d   = seg_end_q;
        aad_cnt_d   = aad_cnt_q;
        pld_cnt_d   = pld_cnt_q;
        aad_done_d  = 1'b0;
        pld_done_d  = 1'b0;
        lens_done_d = 1'b0;

        if (bus.start) begin
            // Abort: pending valids are dropped without a handshake
            state_d    = S_AAD;
            pk_data_d  = '0;
            pk_keep_d  = '0;
            pk_idx_d   = '0;
            out_data_d = '0;
            out_keep_d = '0;
            aad_vld_d  = 1'b0;
            pld_vld_d  = 1'b0;
            len_vld_d  = 1'b0;
            seg_end_d  = 1'b0;
            aad_cnt_d  = '0;
            pld_cnt_d  = '0;
        end else begin
            case (state_q)
                S_AAD, S_PLD: begin
                    if (hs_c) begin
                        aad_vld_d = 1'b0;
                        pld_vld_d = 1'b0;
                    end
                    if (accept_c) begin
                        if (state_q == S_AAD) aad_cnt_d = aad_cnt_q + LEN_W'(pop_c);
                        else                  pld_cnt_d = pld_cnt_q + LEN_W'(pop_c);
                        if (close_c) begin
                            pk_data_d = '0;
                            pk_keep_d = '0;
                            pk_idx_d  = '0;
                            if (emit_c) begin
                                out_data_d = merged_data_c;
                                out_keep_d = merged_keep_c;
                                aad_vld_d  = (state_q == S_AAD);
                                pld_vld_d  = (state_q == S_PLD);
                            end
                        end else begin
                            pk_data_d = merged_data_c;
                            pk_keep_d = merged_keep_c;
                            pk_idx_d  = pk_idx_q + 2'd1;
                        end
                        if (bus.in_last) seg_end_d = 1'b1;
                    end
                    // Segment finishes once its final lane (if any) is taken
                    if (seg_end_q && (out_empty_c || hs_c)) begin
                        seg_end_d = 1'b0;
                        if (state_q == S_AAD) begin
                            aad_done_d = 1'b1;
                            state_d    = S_PLD;
                        end else begin
                            pld_done_d = 1'b1;
                            len_vld_d  = 1'b1;
                            state_d    = S_LEN;
                        end
                    end
                end
                S_LEN: begin
                    if (len_vld_q && bus.len_ready) begin
                        len_vld_d   = 1'b0;
                        lens_done_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pk_data_q   <= '0;
            pk_keep_q   <= '0;
            pk_idx_q    <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            aad_vld_q   <= 1'b0;
            pld_vld_q   <= 1'b0;
            len_vld_q   <= 1'b0;
            seg_end_q   <= 1'b0;
            aad_cnt_q   <= '0;
            pld_cnt_q   <= '0;
            aad_done_q  <= 1'b0;
            pld_done_q  <= 1'b0;
            lens_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pk_data_q   <= pk_data_d;
            pk_keep_q   <= pk_keep_d;
            pk_idx_q    <= pk_idx_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            aad_vld_q   <= aad_vld_d;
            pld_vld_q   <= pld_vld_d;
            len_vld_q   <= len_vld_d;
            seg_end_q   <= seg_end_d;
            aad_cnt_q   <= aad_cnt_d;
            pld_cnt_q   <= pld_cnt_d;
            aad_done_q  <= aad_done_d;
            pld_done_q  <= pld_done_d;
            lens_done_q <= lens_done_d;
        end
    end

`ifdef POLY_PACK_ERRCHK_EN
    logic err_q;
    logic err_hit_c;

    // Protocol violations; data handling is unaffected
    always_comb begin
        err_hit_c = 1'b0;
        if (accept_c) begin
            if (!((bus.in_keep == 4'h0) || (bus.in_keep == 4'h1) || (bus.in_keep == 4'h3) ||
                  (bus.in_keep == 4'h7) || (bus.in_keep == 4'hF)))
                err_hit_c = 1'b1;
            if (!bus.in_last && (bus.in_keep != 4'hF))
                err_hit_c = 1'b1;
        end
        if (bus.in_valid && ((state_q == S_LEN) || (state_q == S_DONE) || (state_q == S_IDLE)))
            err_hit_c = 1'b1;
    end

    // Sticky until the next start
    always_ff @(posedge clk) begin
        if (!rst_n)         err_q <= 1'b0;
        else if (bus.start) err_q <= 1'b0;
        else if (err_hit_c) err_q <= 1'b1;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    // Lane outputs share the single output register
    assign bus.in_ready  = in_ready_c;
    assign bus.aad_valid = aad_vld_q;
    assign bus.aad_data  = out_data_q;
    assign bus.aad_keep  = out_keep_q;
    assign bus.pld_valid = pld_vld_q;
    assign bus.pld_data  = out_data_q;
    assign bus.pld_keep  = out_keep_q;
    assign bus.len_valid = len_vld_q;
    assign bus.len_block = {64'(pld_cnt_q), 64'(aad_cnt_q)};
    assign bus.aad_done  = aad_done_q;
    assign bus.pld_done  = pld_done_q;
    assign bus.lens_done = lens_done_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule
